// File: rtl/tl_a_pkg.sv
// Shared TileLink A-channel definitions: opcodes, fragment class and decode.
package tl_a_pkg;

  localparam logic [2:0] PUT_FULL    = 3'd0;
  localparam logic [2:0] PUT_PARTIAL = 3'd1;
  localparam logic [2:0] ARITH       = 3'd2;
  localparam logic [2:0] LOGIC       = 3'd3;
  localparam logic [2:0] GET         = 3'd4;
  localparam logic [2:0] HINT        = 3'd5;

  // REPEAT: replayed by the repeat buffer; STREAM: arrives beat by beat;
  // ATOMIC: single-beat only (also covers the unused opcodes 6/7).
  typedef enum logic [1:0] {REPEAT, STREAM, ATOMIC} frag_class_e;

  function automatic frag_class_e class_of(input logic [2:0] opcode);
    frag_class_e cls;
    case (opcode)
      GET, HINT:             cls = REPEAT;
      PUT_FULL, PUT_PARTIAL: cls = STREAM;
      default:               cls = ATOMIC;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/tl_frag_addr_gen.sv
// Combinational fragment address/size rewrite, shared with the response merger.
// Address bits [eff_size-1:BEAT_LOG2] take the fragment index, beat offset is zeroed,
// bits at or above eff_size are kept.
module tl_frag_addr_gen #(
  parameter int ADDR_W        = 33,
  parameter int BEAT_LOG2     = 4,
  parameter int MAX_SIZE_LOG2 = 6,
  parameter int CNT_W         = MAX_SIZE_LOG2 - BEAT_LOG2
) (
  input  logic [ADDR_W-1:0] address,
  input  logic [3:0]        eff_size,
  input  logic [CNT_W-1:0]  frag_cnt,
  output logic [ADDR_W-1:0] frag_address,
  output logic [3:0]        frag_size
);

  assign frag_size = 4'(BEAT_LOG2);

  for (genvar gi = 0; gi < ADDR_W; gi++) begin : g_bit
    if (gi < BEAT_LOG2) begin : g_offset
      assign frag_address[gi] = 1'b0;
    end else if (gi < MAX_SIZE_LOG2) begin : g_index
      assign frag_address[gi] = (4'(gi) < eff_size) ? frag_cnt[gi-BEAT_LOG2] : address[gi];
    end else begin : g_high
      assign frag_address[gi] = address[gi];
    end
  end

endmodule

// File: rtl/tl_a_fragment_sequencer.sv
// Splits multi-beat TileLink A requests into beat-sized fragments.
// Get/Hint are replayed by the upstream repeat buffer via repeat_hold;
// Put beats are relabelled as single-beat fragments.
// Optional build macro TL_FRAG_PERF_EN adds perf_requests / perf_fragments counters.
// The buffer's "repeat" control is named repeat_hold since repeat is a reserved word.
import tl_a_pkg::*;

module tl_a_fragment_sequencer #(
  parameter int BEAT_LOG2     = 4,
  parameter int MAX_SIZE_LOG2 = 6,
  parameter int ADDR_W        = 33,
  parameter int SRC_W         = 4,
  parameter int DATA_W        = 8 << BEAT_LOG2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_opcode,
  input  logic [2:0]        in_param,
  input  logic [3:0]        in_size,
  input  logic [SRC_W-1:0]  in_source,
  input  logic [ADDR_W-1:0] in_address,
  input  logic [DATA_W-1:0] in_data,
  output logic              repeat_hold,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2:0]        out_opcode,
  output logic [2:0]        out_param,
  output logic [3:0]        out_size,
  output logic [SRC_W-1:0]  out_source,
  output logic [ADDR_W-1:0] out_address,
  output logic [DATA_W-1:0] out_data,
  output logic              out_first,
  output logic              out_last,
  output logic              out_illegal
`ifdef TL_FRAG_PERF_EN
  ,
  output logic [31:0]       perf_requests,
  output logic [31:0]       perf_fragments
`endif
);

  localparam int         CNT_W     = MAX_SIZE_LOG2 - BEAT_LOG2;
  localparam logic [3:0] MAX_SIZE  = 4'(MAX_SIZE_LOG2);
  localparam logic [3:0] BEAT_SIZE = 4'(BEAT_LOG2);

  logic [CNT_W-1:0]  frag_cnt_reg;
  logic [CNT_W-1:0]  frag_cnt_next;
  frag_class_e       op_class;
  logic [3:0]        eff_size;
  logic [3:0]        shift;
  logic [CNT_W-1:0]  nfrag_m1;
  logic              size_illegal;
  logic              frag_en;
  logic              last;
  logic              fire;
  logic [ADDR_W-1:0] frag_address;
  logic [3:0]        frag_size;

  assign op_class = class_of(in_opcode);
  assign eff_size = (in_size > MAX_SIZE) ? MAX_SIZE : in_size;

  // Oversized requests and multi-beat atomics pass through untouched as one fragment.
  assign size_illegal = (in_size > MAX_SIZE) | ((op_class == ATOMIC) & (in_size > BEAT_SIZE));
  assign frag_en      = ~size_illegal & (eff_size > BEAT_SIZE);

  // Index of the final fragment: low 'shift' bits set.
  assign shift    = eff_size - BEAT_SIZE;
  assign nfrag_m1 = ~({CNT_W{1'b1}} << shift);
  assign last     = frag_en ? (frag_cnt_reg == nfrag_m1) : 1'b1;

  assign fire      = in_valid & out_ready;
  assign out_valid = in_valid;
  assign in_ready  = out_ready;

  // Replay request while more fragments remain; dropped during reset so the
  // buffer and this counter restart together.
  assign repeat_hold = in_valid & ~reset & (op_class == REPEAT) & ~last;

  tl_frag_addr_gen #(
    .ADDR_W       (ADDR_W),
    .BEAT_LOG2    (BEAT_LOG2),
    .MAX_SIZE_LOG2(MAX_SIZE_LOG2),
    .CNT_W        (CNT_W)
  ) u_addr_gen (
    .address     (in_address),
    .eff_size    (eff_size),
    .frag_cnt    (frag_cnt_reg),
    .frag_address(frag_address),
    .frag_size   (frag_size)
  );

  assign out_address = frag_en ? frag_address : in_address;
  assign out_size    = frag_en ? frag_size : in_size;
  assign out_opcode  = in_opcode;
  assign out_param   = in_param;
  assign out_source  = in_source;
  assign out_data    = in_data;
  assign out_first   = (frag_cnt_reg == '0);
  assign out_last    = last;
  assign out_illegal = in_valid & size_illegal;

  assign frag_cnt_next = last ? '0 : frag_cnt_reg + 1'b1;

  // Fragment index: advances on each accepted fragment, wraps after the last one.
  always_ff @(posedge clock) begin
    if (reset) begin
      frag_cnt_reg <= '0;
    end else if (fire) begin
      frag_cnt_reg <= frag_cnt_next;
    end
  end

`ifdef TL_FRAG_PERF_EN
  logic [31:0] perf_requests_reg;
  logic [31:0] perf_fragments_reg;

  // Free-running request/fragment counters, wrapping at 2^32.
  always_ff @(posedge clock) begin
    if (reset) begin
      perf_requests_reg  <= '0;
      perf_fragments_reg <= '0;
    end else if (fire) begin
      perf_fragments_reg <= perf_fragments_reg + 32'd1;
      if (last) perf_requests_reg <= perf_requests_reg + 32'd1;
    end
  end

  assign perf_requests  = perf_requests_reg;
  assign perf_fragments = perf_fragments_reg;
`endif

endmodule

// File: tb/tb_tl_a_fragment_sequencer.sv
// Randomized self-checking bench for tl_a_fragment_sequencer against a
// request-level model (fragment list computed from opcode, size and address).
module tb_tl_a_fragment_sequencer;

  localparam int BEAT_LOG2     = 4;
  localparam int MAX_SIZE_LOG2 = 6;
  localparam int ADDR_W        = 33;
  localparam int SRC_W         = 4;
  localparam int DATA_W        = 128;

  logic              clock = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_opcode;
  logic [2:0]        in_param;
  logic [3:0]        in_size;
  logic [SRC_W-1:0]  in_source;
  logic [ADDR_W-1:0] in_address;
  logic [DATA_W-1:0] in_data;
  logic              repeat_hold;
  logic              out_valid;
  logic              out_ready;
  logic [2:0]        out_opcode;
  logic [2:0]        out_param;
  logic [3:0]        out_size;
  logic [SRC_W-1:0]  out_source;
  logic [ADDR_W-1:0] out_address;
  logic [DATA_W-1:0] out_data;
  logic              out_first;
  logic              out_last;
  logic              out_illegal;
`ifdef TL_FRAG_PERF_EN
  logic [31:0]       perf_requests;
  logic [31:0]       perf_fragments;
`endif

  always #5 clock = ~clock;

  tl_a_fragment_sequencer #(
    .BEAT_LOG2(BEAT_LOG2), .MAX_SIZE_LOG2(MAX_SIZE_LOG2),
    .ADDR_W(ADDR_W), .SRC_W(SRC_W), .DATA_W(DATA_W)
  ) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode), .in_param(in_param),
    .in_size(in_size), .in_source(in_source), .in_address(in_address), .in_data(in_data),
    .repeat_hold(repeat_hold),
    .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode), .out_param(out_param),
    .out_size(out_size), .out_source(out_source), .out_address(out_address), .out_data(out_data),
    .out_first(out_first), .out_last(out_last), .out_illegal(out_illegal)
`ifdef TL_FRAG_PERF_EN
    , .perf_requests(perf_requests), .perf_fragments(perf_fragments)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;
  int model_req = 0;
  int model_frag = 0;

  task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Request-level model
  function automatic bit m_illegal(input logic [2:0] op, input int size);
    bit atomic;
    atomic = !(op inside {3'd0, 3'd1, 3'd4, 3'd5});
    return (size > MAX_SIZE_LOG2) || (atomic && size > BEAT_LOG2);
  endfunction

  function automatic int m_nfrag(input logic [2:0] op, input int size);
    if (m_illegal(op, size) || size <= BEAT_LOG2) return 1;
    return 1 << (size - BEAT_LOG2);
  endfunction

  function automatic logic [ADDR_W-1:0] m_addr(input logic [ADDR_W-1:0] a, input int size,
                                               input int k, input bit frag);
    logic [63:0] w;
    if (!frag) return a;
    w = 64'(a);
    w = (w >> size) << size;
    w = w + 64'(k) * 16;
    return w[ADDR_W-1:0];
  endfunction

  task automatic check_perf(input string tag);
`ifdef TL_FRAG_PERF_EN
    check_eq({tag, "_perf_req"}, 128'(perf_requests), 128'(model_req));
    check_eq({tag, "_perf_frag"}, 128'(perf_fragments), 128'(model_frag));
`else
    if (tag.len() < 0) $display("%s", tag);
`endif
  endtask

  // Issue one request and follow it through all of its fragments.
  task automatic run_request(input logic [2:0] op, input int size, input logic [ADDR_W-1:0] addr,
                             input int gap_pct, input int stall_pct, input bit force_ready_pattern);
    int n, k, cycles, rdy_idx;
    bit ill, frag, is_get, is_stream, v;
    logic [DATA_W-1:0] cur_data;
    logic [2:0] prm;
    logic [SRC_W-1:0] src;
    ill       = m_illegal(op, size);
    n         = m_nfrag(op, size);
    frag      = !ill && size > BEAT_LOG2;
    is_get    = op inside {3'd4, 3'd5};
    is_stream = op inside {3'd0, 3'd1};
    cur_data  = {$urandom, $urandom, $urandom, $urandom};
    prm       = 3'($urandom);
    src       = SRC_W'($urandom);
    k = 0; cycles = 0; rdy_idx = 0;
    while (k < n && cycles < 300) begin
      @(negedge clock);
      cycles++;
      v = ($urandom_range(99) >= 32'(gap_pct));
      in_valid   = v;
      in_opcode  = op;
      in_param   = prm;
      in_size    = 4'(size);
      in_source  = src;
      in_address = addr;
      in_data    = cur_data;
      if (force_ready_pattern) begin
        out_ready = (rdy_idx % 2 == 0);
        rdy_idx++;
      end else begin
        out_ready = ($urandom_range(99) >= 32'(stall_pct));
      end
      #1;
      check_eq("out_valid", 128'(out_valid), 128'(v));
      check_eq("in_ready", 128'(in_ready), 128'(out_ready));
      if (v) begin
        check_eq("out_address", 128'(out_address), 128'(m_addr(addr, size, k, frag)));
        check_eq("out_size", 128'(out_size), frag ? 128'(BEAT_LOG2) : 128'(size));
        check_eq("out_first", 128'(out_first), 128'(k == 0));
        check_eq("out_last", 128'(out_last), 128'(k == n - 1));
        check_eq("repeat", 128'(repeat_hold), 128'(is_get && k != n - 1));
        check_eq("out_illegal", 128'(out_illegal), 128'(ill));
        check_eq("out_data", out_data, cur_data);
        check_eq("out_passthru", 128'({out_opcode, out_param, out_source}), 128'({op, prm, src}));
      end else begin
        check_eq("repeat_idle", 128'(repeat_hold), 128'(0));
        check_eq("illegal_idle", 128'(out_illegal), 128'(0));
      end
      if (v && out_ready) begin
        model_frag++;
        if (k == n - 1) model_req++;
        k++;
        if (is_stream) cur_data = {$urandom, $urandom, $urandom, $urandom};
      end
    end
    if (k < n) check_eq("timeout", 128'(k), 128'(n));
    @(negedge clock);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    check_perf("req");
    $display("req op=%0d size=%0d addr=%0h frags=%0d cycles=%0d", op, size, addr, n, cycles);
  endtask

  initial begin
    logic [ADDR_W-1:0] a;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_opcode = '0; in_param = '0; in_size = '0; in_source = '0; in_address = '0; in_data = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check_eq("rst_out_valid", 128'(out_valid), 128'(0));
    check_eq("rst_repeat", 128'(repeat_hold), 128'(0));
    check_eq("rst_first", 128'(out_first), 128'(1));
    check_perf("rst");

    // Directed cases
    run_request(3'd4, 6, 33'h1_0000_0040, 0, 0, 0);   // Get 64B, always ready
    run_request(3'd4, 5, 33'h0_1234_5660, 0, 0, 1);   // Get 32B, ready toggling
    run_request(3'd0, 6, 33'h0_0000_1000, 30, 0, 0);  // PutFull 64B with gaps
    run_request(3'd4, 3, 33'h0_0000_0008, 0, 0, 0);   // Get 8B, single
    run_request(3'd2, 5, 33'h0_0000_0020, 0, 0, 0);   // ARITH 32B, illegal
    run_request(3'd4, 7, 33'h0_0000_0080, 0, 0, 0);   // Get 128B, illegal
    run_request(3'd4, 6, 33'h0_0000_0000, 0, 0, 0);   // follows illegal: index 0

    // Reset in the middle of a burst
    a = 33'h1_ABCD_0100;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      in_valid = 1'b1; in_opcode = 3'd4; in_size = 4'd6; in_address = a; out_ready = 1'b1;
    end
    @(negedge clock);
    reset = 1'b1;
    #1;
    check_eq("rst_mid_repeat", 128'(repeat_hold), 128'(0));
    @(negedge clock);
    reset = 1'b0; out_ready = 1'b0;
    #1;
    check_eq("rst_mid_first", 128'(out_first), 128'(1));
    check_eq("rst_mid_addr", 128'(out_address), 128'(m_addr(a, 6, 0, 1'b1)));
    check_eq("rst_mid_repeat_after", 128'(repeat_hold), 128'(1));
    model_req = 0; model_frag = 0;
    check_perf("rst_mid");
    run_request(3'd4, 6, a, 0, 0, 0);

    // Randomized requests
    for (int i = 0; i < 150; i++) begin
      run_request(3'($urandom_range(7)), int'($urandom_range(8)),
                  {1'($urandom_range(1)), 32'($urandom)}, 25, 30, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
